// File: rtl/ad7476_spi_rd_if.sv
// Bundles the conversion handshake, the ADC serial pins and the sample output.
// The master modport is the read engine; the slave modport is the fabric/ADC side.
interface ad7476_spi_rd_if;
    logic        start_i;
    logic        busy_o;
    logic        cs_n_o;
    logic        sclk_o;
    logic        sdata_i;
    logic [11:0] data_o;
    logic        data_valid_o;
    logic        lead_err_o;

    modport master (
        input  start_i,
        input  sdata_i,
        output busy_o,
        output cs_n_o,
        output sclk_o,
        output data_o,
        output data_valid_o,
        output lead_err_o
    );

    modport slave (
        output start_i,
        output sdata_i,
        input  busy_o,
        input  cs_n_o,
        input  sclk_o,
        input  data_o,
        input  data_valid_o,
        input  lead_err_o
    );
endinterface

// File: rtl/ad7476_spi_rd.sv
// SPI read master for an AD7476A-class ADC: one 16-bit frame per start request,
// 4 leading zeros then a 12-bit sample, MSB first, with a fabric-side valid strobe.
module ad7476_spi_rd #(
    parameter int CLK_DIV      = 2,
    parameter int QUIET_CYCLES = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    ad7476_spi_rd_if.master   bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_LOW   = 3'd2;
    localparam logic [2:0] S_HIGH  = 3'd3;
    localparam logic [2:0] S_QUIET = 3'd4;

    localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [7:0] QUIET_LAST = 8'(QUIET_CYCLES - 1);
    localparam logic [4:0] LAST_BIT   = 5'd16;

    logic [2:0]  state_q,   state_d;
    logic [7:0]  cnt_q,     cnt_d;
    logic [4:0]  bitCnt_q,  bitCnt_d;
    logic [15:0] shift_q,   shift_d;
    logic        csN_q,     csN_d;
    logic        sclk_q,    sclk_d;
    logic        busy_q,    busy_d;
    logic [11:0] data_q,    data_d;
    logic        valid_q,   valid_d;
    logic        leadErr_q, leadErr_d;

    // Each sclk fall samples sdata_i before the ADC advances it, so the
    // capture and the 1->0 sclk transition are always scheduled together.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bitCnt_d  = bitCnt_q;
        shift_d   = shift_q;
        csN_d     = csN_q;
        sclk_d    = sclk_q;
        busy_d    = busy_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        leadErr_d = leadErr_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    state_d  = S_SETUP;
                    cnt_d    = 8'd0;
                    bitCnt_d = 5'd0;
                    csN_d    = 1'b0;
                    sclk_d   = 1'b1;
                    busy_d   = 1'b1;
                end
            end

            S_SETUP: begin
                if (cnt_q == DIV_LAST) begin
                    state_d  = S_LOW;
                    cnt_d    = 8'd0;
                    sclk_d   = 1'b0;
                    shift_d  = {shift_q[14:0], bus.sdata_i};
                    bitCnt_d = bitCnt_q + 5'd1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            S_LOW: begin
                if (cnt_q == DIV_LAST) begin
                    state_d = S_HIGH;
                    cnt_d   = 8'd0;
                    sclk_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            S_HIGH: begin
                if (cnt_q != DIV_LAST) begin
                    cnt_d = cnt_q + 8'd1;
                end else if (bitCnt_q == LAST_BIT) begin
                    state_d   = S_QUIET;
                    cnt_d     = 8'd0;
                    csN_d     = 1'b1;
                    data_d    = shift_q[11:0];
                    leadErr_d = |shift_q[15:12];
                    valid_d   = 1'b1;
                end else begin
                    state_d  = S_LOW;
                    cnt_d    = 8'd0;
                    sclk_d   = 1'b0;
                    shift_d  = {shift_q[14:0], bus.sdata_i};
                    bitCnt_d = bitCnt_q + 5'd1;
                end
            end

            S_QUIET: begin
                if (cnt_q == QUIET_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
                csN_d   = 1'b1;
                sclk_d  = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // cs_n_o and sclk_o leave straight from these flops so the ADC never sees a glitch.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            bitCnt_q  <= 5'd0;
            shift_q   <= 16'd0;
            csN_q     <= 1'b1;
            sclk_q    <= 1'b1;
            busy_q    <= 1'b0;
            data_q    <= 12'd0;
            valid_q   <= 1'b0;
            leadErr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bitCnt_q  <= bitCnt_d;
            shift_q   <= shift_d;
            csN_q     <= csN_d;
            sclk_q    <= sclk_d;
            busy_q    <= busy_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            leadErr_q <= leadErr_d;
        end
    end

    assign bus.cs_n_o       = csN_q;
    assign bus.sclk_o       = sclk_q;
    assign bus.busy_o       = busy_q;
    assign bus.data_o       = data_q;
    assign bus.data_valid_o = valid_q;
    assign bus.lead_err_o   = leadErr_q;

endmodule

// File: doc/ad7476_spi_rd.md
Name: ad7476_spi_rd

Overview:
- Synthesizable SPI read master for the AD7476A-class serial ADC: 16-bit frame, 4 leading zeros then 12 data bits, MSB first.
- Drives the ADC chip select and serial clock and deserializes the frame.
- Presents the 12-bit sample to the fabric with a one-cycle valid strobe.
- Sits between the sample-rate timer (start_i) and the sample FIFO / wishbone register bank in adc_ad7476_if.

Parameters:
- CLK_DIV, 2, sclk half-period in clk_i cycles; legal range 1..255.
- QUIET_CYCLES, 4, minimum cs_n_o high time between frames in clk_i cycles; legal range 1..255.

Ports:
- clk_i  input  1  system clock; all logic is rising-edge.
- rst_i  input  1  asynchronous, active-high reset.
- start_i  input  1  conversion request, sampled each cycle.
- busy_o  output  1  high while a frame or the quiet time is in progress.
- cs_n_o  output  1  ADC chip select (CS/RD), active low; registered.
- sclk_o  output  1  ADC serial clock; idles high; registered.
- sdata_i  input  1  ADC serial data out.
- data_o  output  12  last received sample; holds its value until the next frame completes.
- data_valid_o  output  1  one-cycle strobe; data_o is updated in the same cycle.
- lead_err_o  output  1  set with data_valid_o when any of the 4 leading bits was 1.

Behaviour:
- Reset values (asynchronous, immediate): cs_n_o=1, sclk_o=1, busy_o=0, data_o=0, data_valid_o=0, lead_err_o=0, state=IDLE, all counters 0, shift register 0.
- State machine: IDLE -> SETUP -> LOW <-> HIGH -> QUIET -> IDLE.
- IDLE:
  - start_i=1 -> SETUP.
  - cs_n_o=0 and busy_o=1 from the next cycle.
- SETUP:
  - cs_n_o=0, sclk_o=1, held for CLK_DIV cycles.
  - The ADC drives bit15 onto sdata_i after CS falls.
- Sampling:
  - On every transition into LOW (sclk_o 1->0), the shift register captures sdata_i, shifting left and inserting at the LSB.
  - The ADC advances its data after sclk falls, so the sample is taken before it changes. The first capture is bit15.
- LOW: sclk_o=0 for CLK_DIV cycles -> HIGH.
- HIGH:
  - sclk_o=1 for CLK_DIV cycles.
  - After the 16th HIGH phase -> QUIET; otherwise -> LOW.
  - Bit counter is 5 bits, counts 0..16, no wrap.
- Entering QUIET:
  - cs_n_o=1.
  - data_o <= shift[11:0]; lead_err_o <= |shift[15:12]; data_valid_o=1 for exactly that one cycle.
- QUIET: cs_n_o=1, sclk_o=1 for QUIET_CYCLES cycles -> IDLE, busy_o=0.
- Timing:
  - cs_n_o is low for exactly 33*CLK_DIV cycles.
  - Exactly 16 sclk falling edges per frame.
  - Latency from start_i to data_valid_o is 1+33*CLK_DIV cycles.
  - A new frame can start, at the earliest, 1+33*CLK_DIV+QUIET_CYCLES cycles after the previous start.
- start_i:
  - Ignored whenever state != IDLE; there is no queuing.
  - A level held high gives back-to-back frames separated by the quiet time.
- lead_err_o is informational only; data_o is still updated.
- rst_i asserted mid-frame:
  - cs_n_o and sclk_o return high immediately.
  - No data_valid_o pulse; data_o=0.
  - The frame restarts only on a new start_i after rst_i deasserts.
- No glitches: cs_n_o and sclk_o come directly from flops.

Test Plan:
- CLK_DIV=2, QUIET_CYCLES=4, ADC model returning 0x0AA5, single start_i pulse:
  - cs_n_o low 66 cycles, 16 sclk falling edges.
  - data_valid_o pulses once, 67 cycles after start.
  - data_o=0xAA5, lead_err_o=0.
- start_i held high for 3 frames, model returning 0x0AA5/0x0AA6/0x0AA7:
  - Three valid strobes with data_o=0xAA5, 0xAA6, 0xAA7.
  - cs_n_o high exactly 4+1 cycles between frames.
- Bench drives sdata_i frame 0xF123 (CLK_DIV=1):
  - data_o=0x123, lead_err_o=1, cs_n_o low 33 cycles.
- start_i pulsed at cycle 10 of an active frame:
  - Ignored: only one frame occurs and busy_o never drops mid-frame.
- rst_i asserted after the 7th sclk fall:
  - cs_n_o=1, sclk_o=1, busy_o=0 asynchronously; no data_valid_o.
  - A subsequent start yields a correct full frame (0x0AA5 from a fresh model).
- CLK_DIV=255, QUIET_CYCLES=1:
  - sclk high/low phases are each exactly 255 cycles.
  - No counter overflow; data_o matches the model value.
